// File: rtl/exec_mem_unit.sv
// ---------------------------------------------------------------------------
// exec_mem_unit
//   Execute/memory datapath slice of the single-cycle CPU.
//   - PC incrementer (pc + 4), branch-target adder and next-PC select.
//   - 32-bit ALU. Its result doubles as the data-memory byte address.
//   - Word-organised data memory:
//       - combinational read;
//       - write on the rising clock edge;
//       - asynchronous clear on reset.
//
// Ports
//   clk            in   1   clock; memory write on rising edge
//   rst_n          in   1   asynchronous active-low reset (clears memory)
//   pc             in   32  current program counter
//   imm_ext        in   32  extended immediate, branch offset in words
//   pc_src         in   1   1 = next PC is the branch target
//   alu_a          in   32  ALU operand A
//   alu_b          in   32  ALU operand B
//   alu_ctr        in   4   ALU operation select
//   mem_write      in   1   store enable
//   mem_wdata      in   32  store data
//   pc_plus4       out  32  pc + 4
//   branch_target  out  32  pc_plus4 + (imm_ext << 2)
//   next_pc        out  32  selected next program counter
//   alu_out        out  32  ALU result / memory byte address
//   zero           out  1   alu_out == 0
//   mem_rdata      out  32  memory word addressed by alu_out
// ---------------------------------------------------------------------------
module exec_mem_unit #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic [31:0] imm_ext,
    input  logic        pc_src,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [3:0]  alu_ctr,
    input  logic        mem_write,
    input  logic [31:0] mem_wdata,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_target,
    output logic [31:0] next_pc,
    output logic [31:0] alu_out,
    output logic        zero,
    output logic [31:0] mem_rdata
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTU = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_LUI  = 4'd11
    } alu_op_e;

    // ---------------- PC path ----------------
    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign next_pc       = pc_src ? branch_target : pc_plus4;

    // ---------------- ALU ----------------
    logic [4:0] shamt;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_out = 32'd0;
        case (alu_op_e'(alu_ctr))
            OP_ADD:  alu_out = alu_a + alu_b;
            OP_SUB:  alu_out = alu_a - alu_b;
            OP_AND:  alu_out = alu_a & alu_b;
            OP_OR:   alu_out = alu_a | alu_b;
            OP_XOR:  alu_out = alu_a ^ alu_b;
            OP_NOR:  alu_out = ~(alu_a | alu_b);
            OP_SLT:  alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            OP_SLTU: alu_out = {31'd0, alu_a < alu_b};
            OP_SLL:  alu_out = alu_a << shamt;
            OP_SRL:  alu_out = alu_a >> shamt;
            OP_SRA:  alu_out = $unsigned($signed(alu_a) >>> shamt);
            OP_LUI:  alu_out = {alu_b[15:0], 16'd0};
            default: alu_out = 32'd0;
        endcase
    end

    assign zero = ~|alu_out;

    // ---------------- Data memory ----------------
    // Byte offset bits and bits above the word index are dropped, so the
    // address space aliases every DEPTH*4 bytes.
    logic [AW-1:0] mem_index;
    assign mem_index = alu_out[AW+1:2];

    // One register per word so the whole array can be cleared
    // asynchronously; the read side is a plain combinational mux.
    logic [31:0] mem_words [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            localparam logic [AW-1:0] WORD_IDX = AW'(gi);
            logic [31:0] word_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= 32'd0;
                end else if (mem_write && (mem_index == WORD_IDX)) begin
                    word_reg <= mem_wdata;
                end
            end

            assign mem_words[gi] = word_reg;
        end
    endgenerate

    assign mem_rdata = mem_words[mem_index];

endmodule

// File: tb/tb_exec_mem_unit.sv
module tb_exec_mem_unit;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc, imm_ext, alu_a, alu_b, mem_wdata;
    logic        pc_src, mem_write;
    logic [3:0]  alu_ctr;
    logic [31:0] pc_plus4, branch_target, next_pc, alu_out, mem_rdata;
    logic        zero;

    int vectors = 0;
    int miscompares = 0;

    // Reference memory contents, indexed by word.
    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    exec_mem_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .imm_ext(imm_ext), .pc_src(pc_src),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
        .mem_write(mem_write), .mem_wdata(mem_wdata),
        .pc_plus4(pc_plus4), .branch_target(branch_target), .next_pc(next_pc),
        .alu_out(alu_out), .zero(zero), .mem_rdata(mem_rdata)
    );

    // ---------------- reference model ----------------
    function automatic int addr_to_word(input logic [31:0] addr);
        return int'((longint'(addr) / 4) % DEPTH);
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input int op);
        longint unsigned ua, ub, pw;
        longint sa, sb;
        ua = longint'(a);
        ub = longint'(b);
        sa = (a >= 32'h8000_0000) ? longint'(a) - 64'sh1_0000_0000 : longint'(a);
        sb = (b >= 32'h8000_0000) ? longint'(b) - 64'sh1_0000_0000 : longint'(b);
        pw = 64'd1 << (ub % 32);
        case (op)
            0:  return 32'((ua + ub) % 64'h1_0000_0000);
            1:  return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return ~(a | b);
            6:  return (sa < sb) ? 32'd1 : 32'd0;
            7:  return (ua < ub) ? 32'd1 : 32'd0;
            8:  return 32'((ua * pw) % 64'h1_0000_0000);
            9:  return 32'(ua / pw);
            // Arithmetic shift right == floor division by 2^sh.
            10: return (sa < 0) ? ~(32'((~ua & 64'hFFFF_FFFF) / pw)) : 32'(ua / pw);
            11: return 32'((ub % 65536) * 65536);
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        int idx;
        // Reset is asserted: memory reads 0, combinational paths unaffected.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            alu_a = $urandom; alu_b = 32'd0; alu_ctr = 4'd0;
            mem_write = 1'b1; mem_wdata = $urandom;
            pc = 32'h40 + 32'(i * 4); imm_ext = 32'd0; pc_src = 1'b0;
            #1;
            vectors++;
            if (mem_rdata !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_rdata: got %h expected %h", mem_rdata, 32'd0);
            end
            vectors++;
            if (pc_plus4 !== pc + 32'd4) begin
                miscompares++;
                $display("FAIL reset_pc_plus4: got %h expected %h", pc_plus4, pc + 32'd4);
            end
        end
        @(negedge clk);
        mem_write = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
        for (int i = 0; i < 4; i++) begin
            alu_a = 32'(i * 4 + 8); #1;
            idx = addr_to_word(alu_a);
            vectors++;
            if (mem_rdata !== model_mem[idx]) begin
                miscompares++;
                $display("FAIL post_reset_rdata: addr %h got %h expected %h",
                         alu_a, mem_rdata, model_mem[idx]);
            end
        end
    endtask

    task automatic test_pc_path();
        logic [31:0] e_p4, e_bt, e_np;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i < 2) begin
                pc = 32'h100; imm_ext = 32'hFFFF_FFFF; pc_src = (i == 1);
            end else begin
                pc = $urandom; imm_ext = $urandom; pc_src = 1'($urandom);
            end
            #1;
            e_p4 = 32'((longint'(pc) + 4) % 64'h1_0000_0000);
            e_bt = 32'((longint'(e_p4) + longint'(imm_ext) * 4) % 64'h1_0000_0000);
            e_np = pc_src ? e_bt : e_p4;
            vectors++;
            if (pc_plus4 !== e_p4 || branch_target !== e_bt || next_pc !== e_np) begin
                miscompares++;
                $display("FAIL pc_path: pc %h imm %h src %b got p4=%h bt=%h np=%h expected p4=%h bt=%h np=%h",
                         pc, imm_ext, pc_src, pc_plus4, branch_target, next_pc, e_p4, e_bt, e_np);
            end
        end
    endtask

    task automatic apply_alu(input logic [31:0] a, input logic [31:0] b, input int op,
                             input string name);
        logic [31:0] e;
        @(negedge clk);
        alu_a = a; alu_b = b; alu_ctr = 4'(op); mem_write = 1'b0;
        #1;
        e = ref_alu(a, b, op);
        vectors++;
        if (alu_out !== e || zero !== (e == 32'd0)) begin
            miscompares++;
            $display("FAIL alu_%s: a %h b %h op %0d got %h z=%b expected %h z=%b",
                     name, a, b, op, alu_out, zero, e, (e == 32'd0));
        end
    endtask

    task automatic test_alu_directed();
        apply_alu(32'h7FFF_FFFF, 32'd1,       0,  "add_wrap");
        apply_alu(32'd5,         32'd5,       1,  "sub_zero");
        apply_alu(32'hFFFF_FFFF, 32'd1,       6,  "slt");
        apply_alu(32'hFFFF_FFFF, 32'd1,       7,  "sltu");
        apply_alu(32'hF0F0_F0F0, 32'h0FF0,    2,  "and");
        apply_alu(32'hF0F0_F0F0, 32'h0FF0,    5,  "nor");
        apply_alu(32'h8000_0000, 32'h21,      10, "sra");
        apply_alu(32'h8000_0000, 32'h21,      9,  "srl");
        apply_alu(32'h0,         32'h1234,    11, "lui");
        apply_alu(32'h1234_5678, 32'h9ABC,    15, "undef15");
        apply_alu(32'hFFFF_FFFF, 32'hFFFF,    12, "undef12");
        // Fixed expectations from the worked examples, independent of the model.
        @(negedge clk);
        alu_a = 32'h8000_0000; alu_b = 32'h21; alu_ctr = 4'd10; #1;
        vectors++;
        if (alu_out !== 32'hC000_0000) begin
            miscompares++;
            $display("FAIL sra_const: got %h expected %h", alu_out, 32'hC000_0000);
        end
        alu_a = 32'h7FFF_FFFF; alu_b = 32'd1; alu_ctr = 4'd0; #1;
        vectors++;
        if (alu_out !== 32'h8000_0000 || zero !== 1'b0) begin
            miscompares++;
            $display("FAIL add_const: got %h z=%b expected 80000000 z=0", alu_out, zero);
        end
    endtask

    task automatic test_alu_random();
        logic [31:0] a, b;
        for (int i = 0; i < 300; i++) begin
            a = $urandom; b = $urandom;
            if (i % 5 == 0) b = a;
            apply_alu(a, b, int'($urandom_range(0, 15)), "rand");
        end
    endtask

    task automatic check_read(input logic [31:0] addr, input string name);
        int idx;
        alu_a = addr; alu_b = 32'd0; alu_ctr = 4'd0;
        #1;
        idx = addr_to_word(addr);
        vectors++;
        if (mem_rdata !== model_mem[idx]) begin
            miscompares++;
            $display("FAIL %s: addr %h got %h expected %h", name, addr, mem_rdata, model_mem[idx]);
        end
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic we);
        @(negedge clk);
        alu_a = addr; alu_b = 32'd0; alu_ctr = 4'd0;
        mem_write = we; mem_wdata = data;
        #1;
        // Same-cycle read returns the old contents.
        check_read(addr, "store_old_read");
        @(posedge clk);
        if (we) model_mem[addr_to_word(addr)] = data;
        #1;
        mem_write = 1'b0;
    endtask

    task automatic test_store_load();
        do_store(32'h10, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        check_read(32'h10, "load_0x10");
        check_read(32'h13, "load_0x13");
        check_read(32'h10 + DEPTH * 4, "load_alias");
        vectors++;
        if (mem_rdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL load_const: got %h expected %h", mem_rdata, 32'hDEAD_BEEF);
        end
        do_store(32'h10, 32'h1111_2222, 1'b0);
        do_store(32'h14, 32'h1234_5678, 1'b1);
        @(negedge clk);
        check_read(32'h10, "no_write_0x10");
        check_read(32'h14, "load_0x14");
    endtask

    task automatic test_mem_random();
        logic [31:0] addr;
        for (int i = 0; i < 200; i++) begin
            addr = (i % 4 == 0) ? $urandom : 32'($urandom_range(0, 511));
            do_store(addr, $urandom, 1'($urandom));
            // Right after the edge the new value must already be visible.
            check_read(addr, "after_edge_read");
        end
    endtask

    task automatic test_reset_mid_store();
        @(negedge clk);
        alu_a = 32'h10; alu_b = 32'd0; alu_ctr = 4'd0;
        mem_write = 1'b1; mem_wdata = 32'hCAFE_F00D;
        #1 rst_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
        #1;
        check_read(32'h10, "rst_async_0x10");
        check_read(32'h14, "rst_async_0x14");
        alu_a = 32'h10;
        @(posedge clk);
        #1;
        check_read(32'h10, "rst_store_discarded");
        @(negedge clk);
        mem_write = 1'b0;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) check_read(32'($urandom_range(0, 1023)), "rst_all_zero");
    endtask

    initial begin
        rst_n = 1'b1;
        pc = 32'd0; imm_ext = 32'd0; pc_src = 1'b0;
        alu_a = 32'd0; alu_b = 32'd0; alu_ctr = 4'd0;
        mem_write = 1'b0; mem_wdata = 32'd0;
        #2 rst_n = 1'b0;
        test_reset();
        test_pc_path();
        test_alu_directed();
        test_alu_random();
        test_store_load();
        test_mem_random();
        test_reset_mid_store();
        test_mem_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
